projectile_pool: RTL and testbench

//  Fixed-slot bullet table for the tank arena, replacing ad-hoc compacted bullet arrays.

---
 rtl/tank_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/projectile_pool.sv | 198 +++++++++++++++++++
 tb/tb_projectile_pool.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared tank-arena types: bullet directions, render category codes, arena size.
package tank_pkg;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        WALL   = 2'd1,
        TANK   = 2'd2,
        BULLET = 2'd3
    } cat_t;

    typedef enum logic {
        POOL_IDLE  = 1'b0,
        POOL_SWEEP = 1'b1
    } pool_state_t;

    localparam int DEFAULT_WIDTH  = 60;
    localparam int DEFAULT_HEIGHT = 45;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, searching from the channel after the last grantee.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    // ptr_q holds the highest-priority channel for the next grant.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                ptr_d        = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance_i && found) begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/projectile_pool.sv
// Fixed-slot bullet table: round-robin spawns, per-tick one-slot-per-cycle sweep, render query.
// Optional target-box collision is built when PROJ_COLLISION_EN is defined.
module projectile_pool
    import tank_pkg::*;
#(
    parameter int MAX_BULLETS = 16,
    parameter int N_SHOOTERS  = 4,
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int HEIGHT      = DEFAULT_HEIGHT,
    parameter int CW          = 10,
    parameter int TGT_SIZE    = 3
) (
    input  logic                             clk_100mhz,
    input  logic                             rst,
    input  logic                             tick,
    input  logic [N_SHOOTERS-1:0]            spawn_req,
    input  logic [N_SHOOTERS*CW-1:0]         spawn_x,
    input  logic [N_SHOOTERS*CW-1:0]         spawn_y,
    input  logic [N_SHOOTERS*2-1:0]          spawn_dir,
    output logic [N_SHOOTERS-1:0]            spawn_ack,
    input  logic [CW-1:0]                    cell_x,
    input  logic [CW-1:0]                    cell_y,
    output logic                             cell_hit,
    output logic [$clog2(MAX_BULLETS+1)-1:0] count,
    output logic                             busy,
    output logic                             overrun,
    input  logic [CW-1:0]                    tgt_x,
    input  logic [CW-1:0]                    tgt_y,
    output logic                             tgt_hit
);

    localparam int PW    = $clog2(MAX_BULLETS);
    localparam int CNT_W = $clog2(MAX_BULLETS+1);

    pool_state_t          state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [MAX_BULLETS-1:0] valid_q;
    logic [CW-1:0]        x_q   [MAX_BULLETS];
    logic [CW-1:0]        y_q   [MAX_BULLETS];
    dir_t                 dir_q [MAX_BULLETS];
    logic [CNT_W-1:0]     count_q;
    logic [N_SHOOTERS-1:0] ack_q;
    logic                 cell_hit_q, overrun_q;

    logic                 free_any;
    logic [PW-1:0]        free_idx;
    logic [N_SHOOTERS-1:0] arb_req, grant;
    logic [CW-1:0]        sel_x, sel_y;
    dir_t                 sel_dir;
    logic                 spawn_ok;
    logic                 cur_valid, off_edge, in_tgt, sweeping, retire, move;
    logic [CW-1:0]        cur_x, cur_y, nx, ny;
    dir_t                 cur_dir;
    logic                 hit_any;

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = MAX_BULLETS-1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = PW'(i);
            end
        end
    end

    // A channel whose ack is on the wire is still showing its old request; mask it for that cycle.
    assign arb_req = (state_q == POOL_IDLE && !tick && free_any) ? (spawn_req & ~ack_q) : '0;

    rr_arbiter #(.N(N_SHOOTERS)) u_arb (
        .clk       (clk_100mhz),
        .rst       (rst),
        .req_i     (arb_req),
        .advance_i (|arb_req),
        .grant_o   (grant)
    );

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_dir = LEFT;
        for (int c = 0; c < N_SHOOTERS; c++) begin
            if (grant[c]) begin
                sel_x   = spawn_x[c*CW +: CW];
                sel_y   = spawn_y[c*CW +: CW];
                sel_dir = dir_t'(spawn_dir[c*2 +: 2]);
            end
        end
    end

    assign spawn_ok = (|grant) && (sel_x < CW'(WIDTH)) && (sel_y < CW'(HEIGHT));

    assign sweeping  = (state_q == POOL_SWEEP);
    assign cur_valid = valid_q[ptr_q];
    assign cur_x     = x_q[ptr_q];
    assign cur_y     = y_q[ptr_q];
    assign cur_dir   = dir_q[ptr_q];

    always_comb begin
        off_edge = 1'b0;
        nx       = cur_x;
        ny       = cur_y;
        unique case (cur_dir)
            LEFT:  if (cur_x == '0)              off_edge = 1'b1; else nx = cur_x - CW'(1);
            RIGHT: if (cur_x == CW'(WIDTH-1))    off_edge = 1'b1; else nx = cur_x + CW'(1);
            UP:    if (cur_y == '0)              off_edge = 1'b1; else ny = cur_y - CW'(1);
            DOWN:  if (cur_y == CW'(HEIGHT-1))   off_edge = 1'b1; else ny = cur_y + CW'(1);
        endcase
    end

`ifdef PROJ_COLLISION_EN
    logic [CW:0] tx_end, ty_end;
    assign tx_end = {1'b0, tgt_x} + (CW+1)'(TGT_SIZE);
    assign ty_end = {1'b0, tgt_y} + (CW+1)'(TGT_SIZE);
    assign in_tgt = !off_edge
                    && (nx >= tgt_x) && ({1'b0, nx} < tx_end)
                    && (ny >= tgt_y) && ({1'b0, ny} < ty_end);
`else
    logic unused_tgt;
    assign unused_tgt = ^{tgt_x, tgt_y, TGT_SIZE[0]};
    assign in_tgt     = 1'b0;
`endif

    assign retire  = sweeping && cur_valid && (off_edge || in_tgt);
    assign move    = sweeping && cur_valid && !off_edge && !in_tgt;
    assign tgt_hit = sweeping && cur_valid && in_tgt;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            POOL_IDLE: begin
                if (tick) begin
                    state_d = POOL_SWEEP;
                    ptr_d   = '0;
                end
            end
            POOL_SWEEP: begin
                if (ptr_q == PW'(MAX_BULLETS-1)) state_d = POOL_IDLE;
                else                             ptr_d   = ptr_q + PW'(1);
            end
        endcase
    end

    always_comb begin
        hit_any = 1'b0;
        for (int i = 0; i < MAX_BULLETS; i++) begin
            if (valid_q[i] && x_q[i] == cell_x && y_q[i] == cell_y) hit_any = 1'b1;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state_q    <= POOL_IDLE;
            ptr_q      <= '0;
            valid_q    <= '0;
            count_q    <= '0;
            ack_q      <= '0;
            cell_hit_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ack_q      <= grant;
            cell_hit_q <= hit_any;
            overrun_q  <= tick && sweeping;
            // Spawns happen only in IDLE and retires only in SWEEP, so the count never sees both.
            if (spawn_ok) begin
                valid_q[free_idx] <= 1'b1;
                count_q           <= count_q + CNT_W'(1);
            end
            if (retire) begin
                valid_q[ptr_q] <= 1'b0;
                count_q        <= count_q - CNT_W'(1);
            end
        end
    end

    // NOTE: slot payload is deliberately not reset; valid_q alone decides whether a slot is live.
    always_ff @(posedge clk_100mhz) begin
        if (spawn_ok) begin
            x_q[free_idx]   <= sel_x;
            y_q[free_idx]   <= sel_y;
            dir_q[free_idx] <= sel_dir;
        end
        if (move) begin
            x_q[ptr_q] <= nx;
            y_q[ptr_q] <= ny;
        end
    end

    assign spawn_ack = ack_q;
    assign cell_hit  = cell_hit_q;
    assign count     = count_q;
    assign busy      = sweeping;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_projectile_pool.sv
// Self-checking bench for projectile_pool: ack scoreboard plus direct checks of count, hits, busy.
// Define PROJ_COLLISION_EN on both RTL and bench to exercise the target-box path.
module tb_projectile_pool;
    import tank_pkg::*;

    localparam int MAXB  = 16;
    localparam int NS    = 4;
    localparam int CW    = 10;
    localparam int CNT_W = $clog2(MAXB+1);

    logic               clk_100mhz = 1'b0;
    logic               rst = 1'b1;
    logic               tick = 1'b0;
    logic [NS-1:0]      spawn_req = '0;
    logic [NS*CW-1:0]   spawn_x = '0;
    logic [NS*CW-1:0]   spawn_y = '0;
    logic [NS*2-1:0]    spawn_dir = '0;
    logic [NS-1:0]      spawn_ack;
    logic [CW-1:0]      cell_x = '0;
    logic [CW-1:0]      cell_y = '0;
    logic               cell_hit;
    logic [CNT_W-1:0]   count;
    logic               busy, overrun;
    logic [CW-1:0]      tgt_x = '0;
    logic [CW-1:0]      tgt_y = '0;
    logic               tgt_hit;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ack_q[$];
    int tgt_cnt = 0;
    bit mon_en = 1'b0;

    projectile_pool #(.MAX_BULLETS(MAXB), .N_SHOOTERS(NS), .CW(CW)) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .tick       (tick),
        .spawn_req  (spawn_req),
        .spawn_x    (spawn_x),
        .spawn_y    (spawn_y),
        .spawn_dir  (spawn_dir),
        .spawn_ack  (spawn_ack),
        .cell_x     (cell_x),
        .cell_y     (cell_y),
        .cell_hit   (cell_hit),
        .count      (count),
        .busy       (busy),
        .overrun    (overrun),
        .tgt_x      (tgt_x),
        .tgt_y      (tgt_y),
        .tgt_hit    (tgt_hit)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Ack scoreboard: every ack must match the oldest outstanding request; the requester then drops it.
    always @(negedge clk_100mhz) begin
        if (mon_en) begin
            if (tgt_hit === 1'b1) tgt_cnt++;
            if (spawn_ack !== '0) begin
                check("ack_while_busy", 32'(busy), 32'd0);
                if (exp_ack_q.size() == 0) begin
                    check("ack_unexpected", 32'(spawn_ack), 32'd0);
                end else begin
                    check("ack_order", 32'(spawn_ack), 32'(1) << exp_ack_q.pop_front());
                end
                spawn_req = spawn_req & ~spawn_ack;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_100mhz);
        rst = 1'b1;
        tick = 1'b0;
        spawn_req = '0;
        exp_ack_q.delete();
        repeat (2) @(negedge clk_100mhz);
        rst = 1'b0;
    endtask

    task automatic post_spawn(input int ch, input int x, input int y, input dir_t d);
        @(negedge clk_100mhz);
        spawn_x[ch*CW +: CW] = CW'(x);
        spawn_y[ch*CW +: CW] = CW'(y);
        spawn_dir[ch*2 +: 2] = d;
        spawn_req[ch] = 1'b1;
        exp_ack_q.push_back(ch);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_100mhz);
            #1;
            if (exp_ack_q.size() == 0 && spawn_req == '0) return;
        end
        check({tag, "_drain_timeout"}, 32'(exp_ack_q.size()), 32'd0);
        exp_ack_q.delete();
        spawn_req = '0;
    endtask

    task automatic spawn(input int ch, input int x, input int y, input dir_t d);
        post_spawn(ch, x, y, d);
        wait_drain("spawn");
    endtask

    task automatic do_tick();
        @(negedge clk_100mhz);
        tick = 1'b1;
        @(negedge clk_100mhz);
        tick = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (busy === 1'b0) return;
            @(negedge clk_100mhz);
        end
        check("sweep_timeout", 32'(busy), 32'd0);
    endtask

    task automatic query(input string tag, input int x, input int y, input logic exp);
        @(negedge clk_100mhz);
        cell_x = CW'(x);
        cell_y = CW'(y);
        @(negedge clk_100mhz);
        check(tag, 32'(cell_hit), 32'(exp));
    endtask

    initial begin
        int busy_cnt;
        int ovr_cnt;

        do_reset();
        mon_en = 1'b1;
        @(negedge clk_100mhz);
        check("rst_ack", 32'(spawn_ack), 32'd0);
        check("rst_hit", 32'(cell_hit), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_tgt_hit", 32'(tgt_hit), 32'd0);

        // 1: single spawn, ack one cycle after the grant cycle.
        post_spawn(0, 5, 5, RIGHT);
        @(negedge clk_100mhz);
        check("t1_ack_latency", 32'(spawn_ack), 32'b0001);
        check("t1_count", 32'(count), 32'd1);
        wait_drain("t1");
        query("t1_hit_5_5", 5, 5, 1'b1);
        query("t1_miss_6_5", 6, 5, 1'b0);

        // 2: right-edge move then retire; out-of-range spawn acked but not stored.
        do_reset();
        spawn(1, 58, 10, RIGHT);
        do_tick();
        check("t2_count_after_move", 32'(count), 32'd1);
        query("t2_hit_59_10", 59, 10, 1'b1);
        query("t2_miss_58_10", 58, 10, 1'b0);
        do_tick();
        check("t2_count_after_retire", 32'(count), 32'd0);
        query("t2_retired_59_10", 59, 10, 1'b0);
        spawn(2, 60, 3, UP);
        check("t2_oob_count", 32'(count), 32'd0);
        query("t2_oob_miss", 60, 3, 1'b0);

        // 3: four simultaneous requests granted in channel order.
        do_reset();
        @(negedge clk_100mhz);
        for (int c = 0; c < NS; c++) begin
            spawn_x[c*CW +: CW] = CW'(10 + c);
            spawn_y[c*CW +: CW] = CW'(5);
            spawn_dir[c*2 +: 2] = UP;
            exp_ack_q.push_back(c);
        end
        spawn_req = '1;
        wait_drain("t3");
        check("t3_count", 32'(count), 32'd4);
        for (int c = 0; c < NS; c++) query("t3_hit", 10 + c, 5, 1'b1);

        // 4: full table blocks a request until a bullet retires.
        do_reset();
        spawn(0, 0, 3, LEFT);
        for (int i = 1; i < MAXB; i++) spawn(i % NS, 5 + i, 20, DOWN);
        check("t4_count_full", 32'(count), 32'(MAXB));
        post_spawn(1, 30, 30, UP);
        repeat (8) @(negedge clk_100mhz);
        check("t4_pending", 32'(exp_ack_q.size()), 32'd1);
        check("t4_count_still_full", 32'(count), 32'(MAXB));
        do_tick();
        wait_drain("t4");
        check("t4_count_after", 32'(count), 32'(MAXB));
        query("t4_new_bullet", 30, 30, 1'b1);
        query("t4_retired", 0, 3, 1'b0);
        query("t4_moved", 6, 21, 1'b1);

        // 5: second tick mid-sweep flags overrun once; sweep length is fixed.
        do_reset();
        @(negedge clk_100mhz);
        tick = 1'b1;
        busy_cnt = 0;
        ovr_cnt  = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_100mhz);
            if (busy === 1'b1) busy_cnt++;
            if (overrun === 1'b1) ovr_cnt++;
            tick = (k == 3);
        end
        check("t5_busy_cycles", 32'(busy_cnt), 32'(MAXB));
        check("t5_overrun_pulses", 32'(ovr_cnt), 32'd1);

        // 6: bullet stepping into the target box.
        do_reset();
        tgt_x = CW'(20);
        tgt_y = CW'(20);
        spawn(3, 19, 21, RIGHT);
        tgt_cnt = 0;
        do_tick();
`ifdef PROJ_COLLISION_EN
        check("t6_tgt_pulses", 32'(tgt_cnt), 32'd1);
        check("t6_count", 32'(count), 32'd0);
        query("t6_cell_clear", 20, 21, 1'b0);
`else
        check("t6_tgt_pulses", 32'(tgt_cnt), 32'd0);
        check("t6_count", 32'(count), 32'd1);
        query("t6_cell_moved", 20, 21, 1'b1);
`endif

        // 7: reset in the middle of a sweep.
        do_reset();
        spawn(0, 7, 7, DOWN);
        @(negedge clk_100mhz);
        tick = 1'b1;
        @(negedge clk_100mhz);
        tick = 1'b0;
        repeat (3) @(negedge clk_100mhz);
        check("t7_busy_mid", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk_100mhz);
        check("t7_busy_after_rst", 32'(busy), 32'd0);
        check("t7_count_after_rst", 32'(count), 32'd0);
        rst = 1'b0;
        query("t7_cleared", 7, 8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
